// File: rtl/rom_fetch_unit.sv
// rtl/rom_fetch_unit.sv - instruction fetch sequencer with prefetch buffer for a combinational program ROM
module rom_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned ROM_WORDS  = 513,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        fault,
   output logic [1:0]  state
);

   localparam int unsigned       PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned       CNT_W       = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0]       ROM_WORDS_C = 32'(ROM_WORDS);
   localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic              fault_q, fault_d;

   logic [31:0]       buf_pc_q   [FIFO_DEPTH];
   logic [31:0]       buf_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q;

   logic              pop;
   logic              push;
   logic              flush;
   logic              fifo_full;
   logic              can_enqueue;
   logic              pc_out_of_range;

   // ROM is addressed by word index; the low two pc bits are always zero in legal operation
   assign rom_addr        = {2'b00, fetch_pc_q[31:2]};
   assign pc_out_of_range = ({2'b00, fetch_pc_q[31:2]} >= ROM_WORDS_C);

   assign inst_valid  = (count_q != '0);
   assign inst_data   = inst_valid ? buf_data_q[rd_ptr_q] : '0;
   assign inst_pc     = inst_valid ? buf_pc_q[rd_ptr_q]   : '0;

   assign fifo_full   = (count_q == DEPTH_C);
   assign pop         = inst_valid && inst_ready;
   // a pop in the same cycle frees a slot, so a full buffer can still accept
   assign can_enqueue = !fifo_full || pop;

   assign fault = fault_q;
   assign state = state_q;

   // next-state: redirect beats fault check, fault check beats halt, halt beats fetch
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fault_d    = fault_q;
      push       = 1'b0;
      flush      = 1'b0;

      if (redirect_valid && (state_q != ST_FAULT)) begin
         flush = 1'b1;
         if (redirect_pc[1:0] != 2'b00) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
         end else begin
            fetch_pc_d = redirect_pc;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (can_enqueue && pc_out_of_range) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else if (halt) begin
                  state_d = ST_HALT;
               end else if (can_enqueue) begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
            ST_HALT: begin
               if (!halt) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_FAULT;
            end
         endcase
      end
   end

   // control registers: pc, sequencer state, sticky fault
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         fetch_pc_q <= RESET_PC;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         fault_q    <= fault_d;
      end
   end

   // buffer bookkeeping; flush drops everything including a same-cycle pop
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // buffer storage; contents are only visible through the count-gated head outputs
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
         buf_data_q[wr_ptr_q] <= rom_data;
      end
   end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb/tb_rom_fetch_unit.sv - directed and randomized checks of rom_fetch_unit against a queue model
module tb_rom_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          ROM_WORDS  = 513;
   localparam int          FIFO_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        fault;
   logic [1:0]  state;

   rom_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .ROM_WORDS  (ROM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .fault          (fault),
      .state          (state)
   );

   always #5 clk = ~clk;

   logic [31:0] rom_mem [1024];

   always_comb begin
      rom_data = (rom_addr < 32'd1024) ? rom_mem[rom_addr[9:0]] : 32'hDEAD_BEEF;
   end

   // reference model: pc, queue of {pc,data}, mode 0/1/2, sticky fault
   logic [31:0] m_pc;
   logic [63:0] m_q [$];
   int          m_state;
   bit          m_fault;

   int vectors;
   int miscompares;

   bit          r_r, r_rdy, r_rv, r_h;
   logic [31:0] r_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit rdy, input bit rv,
                               input logic [31:0] rpc, input bit h);
      bit popped;
      popped = (m_q.size() > 0) && rdy;
      if (r) begin
         m_pc    = RESET_PC;
         m_q.delete();
         m_state = 0;
         m_fault = 1'b0;
      end else begin
         if (popped) void'(m_q.pop_front());
         if (rv && m_state != 2) begin
            m_q.delete();
            if (rpc[1:0] != 2'b00) begin
               m_state = 2;
               m_fault = 1'b1;
            end else begin
               m_pc = rpc;
            end
         end else if (m_state == 0) begin
            if (m_q.size() < FIFO_DEPTH && (m_pc >> 2) >= ROM_WORDS) begin
               m_state = 2;
               m_fault = 1'b1;
            end else if (h) begin
               m_state = 1;
            end else if (m_q.size() < FIFO_DEPTH) begin
               m_q.push_back({m_pc, rom_mem[m_pc[11:2]]});
               m_pc = m_pc + 32'd4;
            end
         end else if (m_state == 1 && !h) begin
            m_state = 0;
         end
      end
   endtask

   task automatic step(input bit r, input bit rdy, input bit rv,
                       input logic [31:0] rpc, input bit h);
      @(negedge clk);
      rst            = r;
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt           = h;
      model_update(r, rdy, rv, rpc, h);
      @(posedge clk);
      #1;
      chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
      chk("inst_data",  inst_data, (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0);
      chk("inst_pc",    inst_pc,   (m_q.size() > 0) ? m_q[0][63:32] : 32'h0);
      chk("rom_addr",   rom_addr,  m_pc >> 2);
      chk("state",      32'(state), 32'(m_state));
      chk("fault",      32'(fault), 32'(m_fault));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
      m_pc = RESET_PC; m_state = 0; m_fault = 1'b0;

      // reset release and sequential fetch
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("rst_valid", 32'(inst_valid), 32'h0);
      chk("rst_addr", rom_addr, 32'h0);
      step(0, 1, 0, 0, 0);
      chk("first_pc", inst_pc, 32'h0);
      chk("first_data", inst_data, rom_mem[0]);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);

      // back-pressure fills the buffer
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
      chk("hold_addr", rom_addr, 32'd2);
      chk("hold_data", inst_data, rom_mem[0]);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

      // redirect while full
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 32'h40, 0);
      chk("redir_flush", 32'(inst_valid), 32'h0);
      step(0, 0, 0, 0, 0);
      chk("redir_pc", inst_pc, 32'h40);
      chk("redir_data", inst_data, rom_mem[16]);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

      // halt drains and resumes
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
      chk("halt_state", 32'(state), 32'd1);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);

      // misaligned redirect faults; later redirect ignored; reset recovers
      step(0, 1, 1, 32'h802, 0);
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_state", 32'(state), 32'd2);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 32'h0, 0);
      chk("fault_sticky", 32'(state), 32'd2);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

      // end of ROM, range fault, reset mid-stream
      step(0, 1, 1, 32'h7FC, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
      chk("range_fault", 32'(fault), 32'd1);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("rst_mid_valid", 32'(inst_valid), 32'h0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         r_r   = ($urandom_range(0, 99) < 2) || (m_state == 2 && $urandom_range(0, 9) == 0);
         r_rdy = ($urandom_range(0, 3) != 0);
         r_rv  = ($urandom_range(0, 19) == 0);
         r_pc  = {20'b0, 10'($urandom_range(0, 600)), 2'b00};
         if ($urandom_range(0, 9) == 0) r_pc[1:0] = 2'($urandom_range(1, 3));
         r_h   = ($urandom_range(0, 9) == 0);
         step(r_r, r_rdy, r_rv, r_pc, r_h);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Instruction-fetch sequencer for the word-addressed, combinational-read program ROM.
- Holds the fetch PC and drives the ROM address each cycle.
- Captures returned words into a small FIFO and presents them to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects, an external halt, and out-of-range or misaligned fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, byte address of first fetch after reset; must be 4-byte aligned
ROM_WORDS, 513, number of valid ROM words; word index >= ROM_WORDS is out of range
FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
rom_addr  output  32  ROM word index = fetch_pc >> 2, combinational from fetch_pc
rom_data  input  32  ROM read data, valid same cycle as rom_addr
inst_valid  output  1  FIFO head holds an instruction
inst_ready  input  1  decode accepts head; pop when inst_valid && inst_ready
inst_data  output  32  instruction word at FIFO head
inst_pc  output  32  byte address of inst_data
redirect_valid  input  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  input  32  redirect target byte address
halt  input  1  level: suspend fetching while high
fault  output  1  sticky fetch fault
state  output  2  0=RUN, 1=HALT, 2=FAULT

Behaviour:
Reset:
- While rst is high at a clock edge:
  - fetch_pc <= RESET_PC; FIFO emptied; state <= RUN; fault <= 0.
  - inst_valid=0; inst_data and inst_pc = 0.
- rom_addr = RESET_PC>>2 after reset.
- rst mid-operation discards all buffered instructions and any pending redirect.

Fetch:
- In RUN, a cycle enqueues when FIFO not full OR a pop occurs that same cycle.
  - Enqueued entry is {fetch_pc, rom_data}; fetch_pc <= fetch_pc + 4 (32-bit wrap).
- Latency: enqueue at edge N → inst_valid=1 during cycle N+1.
- First instruction after reset release is valid in the second cycle after rst drops.
- Full FIFO with no pop: no enqueue, fetch_pc holds, rom_addr stable.
- Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.

Redirect:
- Priority: rst > redirect > fault check > halt > normal fetch.
- redirect_valid=1 in cycle N:
  - FIFO flushed at edge N; any pop in cycle N is still considered consumed.
  - No enqueue in cycle N; fetch_pc <= redirect_pc.
  - inst_valid=0 in N+1; target instruction is enqueued at edge N+1 and valid in N+2.
- redirect_pc[1:0] != 0: state <= FAULT, fault <= 1, FIFO flushed, fetch_pc unchanged.
- Redirect accepted in HALT: updates fetch_pc and flushes; state stays HALT.
- Redirect ignored in FAULT.

Range fault:
- Checked in RUN when an enqueue would occur.
- If fetch_pc>>2 >= ROM_WORDS: no enqueue, state <= FAULT, fault <= 1.
- Existing FIFO entries remain and drain normally.

Halt:
- halt=1 in RUN → state HALT next edge; no enqueue in that cycle.
- FIFO keeps draining in HALT.
- halt=0 in HALT → RUN next edge; fetch resumes at held fetch_pc.

FAULT:
- Terminal until rst; no enqueues; fault=1; state=2.
- Draining the FIFO is still allowed.

Handshake:
- inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0.
- inst_ready with inst_valid=0 has no effect.

Test Plan:
- Reset release, inst_ready=1, ROM[0..3]=A,B,C,D → inst_valid from 2nd cycle; consecutive beats (pc,data)=(0,A),(4,B),(8,C),(12,D); rom_addr counts 0,1,2,3.
- inst_ready=0 for 5 cycles after start → FIFO fills at 2 entries; rom_addr holds at 2; inst_data=A stable; on release delivers A,B,C with no gaps or duplicates.
- Redirect to 0x40 while FIFO holds 2 entries → inst_valid=0 next cycle; two cycles later inst_pc=0x40, data=ROM[16]; flushed entries never appear.
- halt high 3 cycles with inst_ready=1 → buffered entries drain, state=1, no new fetches; on halt low fetch resumes at the next sequential pc.
- Redirect to 0x802 → fault=1, state=2, no further enqueues; a later redirect to 0x0 is ignored; rst clears fault and fetch restarts at RESET_PC.
- Redirect to 0x7FC (word 511), inst_ready=1 → words 511 and 512 delivered; fetch at 0x804 (word 513) raises fault; rst asserted mid-stream → next cycle inst_valid=0.
